// File: rtl/loader_pkg.sv
// Shared types and constants for the UART program loader.
// No logic, so no latency.
// No flow control of its own.
package loader_pkg;

  typedef enum logic [2:0] {
    S_REQ,
    S_SIZE,
    S_PROG,
    S_ACK,
    S_DONE,
    S_ERROR
  } loader_state_t;

  localparam logic [7:0] LOADER_REQ_BYTE = 8'h99;
  localparam logic [7:0] LOADER_ACK_BYTE = 8'hAA;

endpackage

// File: rtl/program_loader_packer.sv
// Packs received bytes little-endian into 32-bit words; a flush closes a partial word zero-padded.
// Latency: word_vld pulses 1 cycle after the 4th byte (or the flushing byte).
// Backpressure: none; accepts one byte per cycle, including in the cycle word_vld is high.
module uart_word_packer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        byte_vld,
  input  logic [7:0]  byte_dat,
  input  logic        flush,
  output logic [31:0] word_dat,
  output logic        word_vld,
  output logic [1:0]  lane
);

  logic [31:0] byte_shifted;

  // Place the incoming byte in its lane; upper lanes stay zero for padding.
  always_comb begin
    byte_shifted = {24'd0, byte_dat} << {lane, 3'b000};
  end

  // Accumulate bytes; lane 0 restarts from zero so partial words are zero-filled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_dat <= 32'd0;
      word_vld <= 1'b0;
      lane     <= 2'd0;
    end else begin
      word_vld <= 1'b0;
      if (byte_vld) begin
        word_dat <= (lane == 2'd0) ? byte_shifted : (word_dat | byte_shifted);
        if (lane == 2'd3 || flush) begin
          lane     <= 2'd0;
          word_vld <= 1'b1;
        end else begin
          lane <= lane + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/program_loader.sv
// Boot loader: sends 0x99, takes a 4-byte LE length and the program, writes IMEM words, sends 0xAA.
// Latency: IMEM write 1 cycle after each word's last byte; 0xAA once TX is idle after the final write.
// Backpressure: none on RX (1 byte/strobe); TX waits for uart_tx_busy=0. Option: LOADER_SIZE_CHECK_EN.
module program_loader
  import loader_pkg::*;
#(
  parameter int IMEM_ADDR_W    = 14,
  parameter int IMEM_BASE      = 0,
  parameter int MAX_PROG_BYTES = 65536
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [7:0]             uart_rx_rdata,
  input  logic                   uart_rx_rdata_ready,
  input  logic                   uart_rx_ferr,
  output logic [7:0]             uart_tx_sdata,
  output logic                   uart_tx_start,
  input  logic                   uart_tx_busy,
  output logic                   imem_we,
  output logic [IMEM_ADDR_W-1:0] imem_waddr,
  output logic [31:0]            imem_wdata,
  output logic [31:0]            prog_size,
  output logic                   ferr_seen,
  output logic                   boot_error,
  output logic                   boot_done
);

  loader_state_t state, state_nxt;
  logic          tx_guard;
  logic          tx_fire;
  logic [7:0]    tx_byte;
  logic [1:0]    size_lane;
  logic [31:0]   size_nxt;
  logic [31:0]   byte_cnt;
  logic          rx_good;
  logic          size_acc;
  logic          prog_acc;
  logic          prog_flush;
  logic [1:0]    unused_lane;

  assign rx_good    = uart_rx_rdata_ready && !uart_rx_ferr;
  assign size_acc   = rx_good && (state == S_SIZE);
  // Bytes beyond the announced length are not part of the program.
  assign prog_acc   = rx_good && (state == S_PROG) && (byte_cnt != prog_size);
  assign prog_flush = prog_acc && ((byte_cnt + 32'd1) == prog_size);
  assign boot_done  = (state == S_DONE);

`ifdef LOADER_SIZE_CHECK_EN
  assign boot_error = (state == S_ERROR);
`else
  assign boot_error = 1'b0;
  logic unused_max;
  assign unused_max = (MAX_PROG_BYTES > 0);
`endif

  // Merge the current size byte into its little-endian lane.
  always_comb begin
    size_nxt = prog_size;
    size_nxt[{size_lane, 3'b000} +: 8] = uart_rx_rdata;
  end

  // Next-state and transmit decision; TX waits for idle and skips the cycle after a pulse.
  always_comb begin
    state_nxt = state;
    tx_fire   = 1'b0;
    tx_byte   = LOADER_REQ_BYTE;
    case (state)
      S_REQ: begin
        if (!uart_tx_busy && !tx_guard) begin
          tx_fire   = 1'b1;
          state_nxt = S_SIZE;
        end
      end
      S_SIZE: begin
        if (size_acc && size_lane == 2'd3) begin
          if (size_nxt == 32'd0) state_nxt = S_ACK;
          else                   state_nxt = S_PROG;
`ifdef LOADER_SIZE_CHECK_EN
          if (size_nxt > 32'(MAX_PROG_BYTES)) state_nxt = S_ERROR;
`endif
        end
      end
      S_PROG: begin
        if (imem_we && byte_cnt == prog_size) state_nxt = S_ACK;
      end
      S_ACK: begin
        tx_byte = LOADER_ACK_BYTE;
        if (!uart_tx_busy && !tx_guard) begin
          tx_fire   = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: state_nxt = S_DONE;
`ifdef LOADER_SIZE_CHECK_EN
      S_ERROR: state_nxt = S_ERROR;
`endif
      default: state_nxt = S_REQ;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_REQ;
    else          state <= state_nxt;
  end

  // TX pulse, held data byte, and the one-cycle busy guard after each pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      uart_tx_start <= 1'b0;
      uart_tx_sdata <= 8'd0;
      tx_guard      <= 1'b0;
    end else begin
      uart_tx_start <= tx_fire;
      tx_guard      <= uart_tx_start;
      if (tx_fire) uart_tx_sdata <= tx_byte;
    end
  end

  // Length capture, program byte count and sticky framing-error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prog_size <= 32'd0;
      size_lane <= 2'd0;
      byte_cnt  <= 32'd0;
      ferr_seen <= 1'b0;
    end else begin
      if (size_acc) begin
        prog_size <= size_nxt;
        size_lane <= size_lane + 2'd1;
      end
      if (prog_acc) byte_cnt <= byte_cnt + 32'd1;
      if (uart_rx_rdata_ready && uart_rx_ferr && (state == S_SIZE || state == S_PROG))
        ferr_seen <= 1'b1;
    end
  end

  // Word address: starts at the base when the program begins, wraps at the IMEM size.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              imem_waddr <= '0;
    else if (state == S_SIZE)  imem_waddr <= IMEM_ADDR_W'(IMEM_BASE);
    else if (imem_we)          imem_waddr <= imem_waddr + 1'b1;
  end

  uart_word_packer u_packer (
    .clk      (clk),
    .reset_n  (reset_n),
    .byte_vld (prog_acc),
    .byte_dat (uart_rx_rdata),
    .flush    (prog_flush),
    .word_dat (imem_wdata),
    .word_vld (imem_we),
    .lane     (unused_lane)
  );

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a 4-bit IMEM at base 14 so address wrap is visible.
// Writes and TX pulses are logged by a monitor; the main sequence compares them to hand values.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_program_loader;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [7:0]    uart_rx_rdata = 8'd0;
  logic          uart_rx_rdata_ready = 1'b0;
  logic          uart_rx_ferr = 1'b0;
  logic [7:0]    uart_tx_sdata;
  logic          uart_tx_start;
  logic          uart_tx_busy = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic [31:0]   prog_size;
  logic          ferr_seen;
  logic          boot_error;
  logic          boot_done;

  int total = 0;
  int bad   = 0;

  logic [AW-1:0] wr_addr[$];
  logic [31:0]   wr_data[$];
  logic [7:0]    tx_q[$];

  program_loader #(.IMEM_ADDR_W(AW), .IMEM_BASE(14), .MAX_PROG_BYTES(256)) dut (
    .clk(clk), .reset_n(reset_n),
    .uart_rx_rdata(uart_rx_rdata), .uart_rx_rdata_ready(uart_rx_rdata_ready),
    .uart_rx_ferr(uart_rx_ferr), .uart_tx_sdata(uart_tx_sdata),
    .uart_tx_start(uart_tx_start), .uart_tx_busy(uart_tx_busy),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .prog_size(prog_size), .ferr_seen(ferr_seen), .boot_error(boot_error),
    .boot_done(boot_done)
  );

  always #5 clk = ~clk;

  // Log every IMEM write and every cycle of tx_start (a 2-cycle pulse logs twice).
  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr.push_back(imem_waddr);
      wr_data.push_back(imem_wdata);
    end
    if (uart_tx_start) tx_q.push_back(uart_tx_sdata);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Caller is at a falling edge; consecutive calls give back-to-back strobes.
  task automatic send_byte(input logic [7:0] b, input logic f);
    uart_rx_rdata       = b;
    uart_rx_rdata_ready = 1'b1;
    uart_rx_ferr        = f;
    @(negedge clk);
    uart_rx_rdata_ready = 1'b0;
    uart_rx_ferr        = 1'b0;
  endtask

  task automatic send_size(input logic [31:0] s);
    for (int k = 0; k < 4; k++) send_byte(s[8*k +: 8], 1'b0);
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_o"}, {uart_tx_sdata, uart_tx_start, imem_we, 28'(imem_waddr),
                      ferr_seen, boot_error, boot_done}, 64'd0);
    chk({tag, "_d"}, {imem_wdata, prog_size}, 64'd0);
  endtask

  // Hold reset for a few cycles, clear logs, release, then let the 0x99 go out.
  task automatic boot(input int wait_cycles);
    reset_n = 1'b0;
    idle(3);
    wr_addr.delete(); wr_data.delete(); tx_q.delete();
    reset_n = 1'b1;
    idle(wait_cycles);
  endtask

  initial begin
    // 1: reset state, TX waits for idle, exactly one 0x99
    uart_tx_busy = 1'b1;
    boot(0);
    all_zero("reset");
    idle(5);
    chk("req_wait_busy", tx_q.size(), 0);
    uart_tx_busy = 1'b0;
    idle(6);
    chk("req_count", tx_q.size(), 1);
    chk("req_byte", (tx_q.size() > 0) ? tx_q[0] : 8'h00, 8'h99);
    chk("sdata_hold", uart_tx_sdata, 8'h99);

    // 2: two full words, then 0xAA and boot_done; stray byte afterwards ignored
    send_size(32'd8);
    chk("size8", prog_size, 32'd8);
    send_byte(8'h13, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'h93, 0); send_byte(8'h00, 0); send_byte(8'h10, 0); send_byte(8'h00, 0);
    idle(8);
    chk("t2_nwr", wr_data.size(), 2);
    if (wr_data.size() == 2) begin
      chk("t2_w0", {wr_addr[0], wr_data[0]}, {4'd14, 32'h00000013});
      chk("t2_w1", {wr_addr[1], wr_data[1]}, {4'd15, 32'h00100093});
    end
    chk("t2_tx", tx_q.size(), 2);
    chk("t2_ack", (tx_q.size() > 1) ? tx_q[1] : 8'h00, 8'hAA);
    chk("t2_done", boot_done, 1'b1);
    send_byte(8'h55, 0); send_byte(8'h66, 0); send_byte(8'h77, 0); send_byte(8'h88, 0);
    idle(4);
    chk("t2_ignore", wr_data.size(), 2);

    // 3: partial final word is zero padded
    boot(4);
    send_size(32'd5);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
    send_byte(8'h44, 0); send_byte(8'h55, 0);
    idle(8);
    chk("t3_nwr", wr_data.size(), 2);
    if (wr_data.size() == 2) begin
      chk("t3_w0", {wr_addr[0], wr_data[0]}, {4'd14, 32'h44332211});
      chk("t3_w1", {wr_addr[1], wr_data[1]}, {4'd15, 32'h00000055});
    end
    chk("t3_ack", (tx_q.size() == 2) ? tx_q[1] : 8'h00, 8'hAA);

    // 4: zero length, 0xAA held off by busy
    boot(4);
    uart_tx_busy = 1'b1;
    send_size(32'd0);
    idle(5);
    chk("t4_ack_wait", {tx_q.size(), 31'd0, boot_done}, {32'd1, 32'd0});
    uart_tx_busy = 1'b0;
    idle(5);
    chk("t4_nwr", wr_data.size(), 0);
    chk("t4_ack", (tx_q.size() == 2) ? tx_q[1] : 8'h00, 8'hAA);
    chk("t4_done", boot_done, 1'b1);

    // 5a: framing-errored byte dropped mid-program
    boot(4);
    send_size(32'd4);
    send_byte(8'hA1, 0); send_byte(8'hFF, 1);
    send_byte(8'hB2, 0); send_byte(8'hC3, 0); send_byte(8'hD4, 0);
    idle(6);
    chk("t5_ferr", ferr_seen, 1'b1);
    chk("t5_w0", (wr_data.size() == 1) ? {wr_addr[0], wr_data[0]} : 36'd0,
        {4'd14, 32'hD4C3B2A1});
    chk("t5_done", boot_done, 1'b1);

    // 5b: reset mid-program clears everything, then a fresh request
    boot(4);
    send_size(32'd8);
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0);
    reset_n = 1'b0;
    idle(1);
    all_zero("midreset");
    boot(6);
    chk("t5_fresh", (tx_q.size() == 1) ? tx_q[0] : 8'h00, 8'h99);
    chk("t5_nwr", wr_data.size(), 0);

    // 6: length 0x104 against MAX_PROG_BYTES=256
    boot(4);
    send_size(32'h104);
    for (int i = 0; i < 260; i++) send_byte(8'(i), 0);
    idle(8);
`ifdef LOADER_SIZE_CHECK_EN
    chk("t6_err", boot_error, 1'b1);
    chk("t6_nwr", wr_data.size(), 0);
    chk("t6_noack", tx_q.size(), 1);
    chk("t6_nodone", boot_done, 1'b0);
`else
    chk("t6_err", boot_error, 1'b0);
    chk("t6_nwr", wr_data.size(), 65);
    if (wr_data.size() == 65) begin
      chk("t6_wrap", {wr_addr[2], wr_data[2]}, {4'd0, 32'h0B0A0908});
      chk("t6_last", {wr_addr[64], wr_data[64]}, {4'd14, 32'h03020100});
    end
    chk("t6_ack", (tx_q.size() == 2) ? tx_q[1] : 8'h00, 8'hAA);
    chk("t6_done", boot_done, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
